// File: rtl/axis_vector_driver_pkg.sv
// Shared definitions for the AXIS vector driver: FSM state encoding and default sizes.
package axis_vector_pkg;
    localparam int DEFAULT_DATA_WIDTH = 128;
    localparam int DEFAULT_TX_WORDS   = 10;
    localparam int DEFAULT_RX_WORDS   = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        RECV = 2'd2,
        DONE = 2'd3
    } state_t;
endpackage

// File: rtl/axis_vector_driver_if.sv
// AXI4-Stream channel bundle used for both the outgoing and the incoming stream.
interface axis_vector_driver_if
    import axis_vector_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
    // A beat transfers on a rising edge where tvalid and tready are both high; once
    // tvalid is raised the master holds tdata/tkeep/tlast steady until that transfer.
    logic                    tvalid;
    logic                    tready;
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tlast;

    modport master (output tvalid, tdata, tkeep, tlast, input tready);
    modport slave  (input tvalid, tdata, tkeep, tlast, output tready);
endinterface

// File: rtl/axis_vector_driver.sv
// Sends a request vector as one AXIS packet, then captures one response packet into a
// vector and presents it with a malformed-packet flag. One transaction at a time.
module axis_vector_driver
    import axis_vector_pkg::*;
#(
    parameter int C_DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int TX_WORDS_NUM = DEFAULT_TX_WORDS,
    parameter int RX_WORDS_NUM = DEFAULT_RX_WORDS
) (
    input  logic                                 s_axis_aclk,
    input  logic                                 s_axis_aresetn,
    input  logic                                 req_valid,
    output logic                                 req_ready,
    input  logic [C_DATA_WIDTH*TX_WORDS_NUM-1:0] req_data,
    output logic                                 rsp_valid,
    input  logic                                 rsp_ready,
    output logic [C_DATA_WIDTH*RX_WORDS_NUM-1:0] rsp_data,
    output logic                                 rsp_err,
    axis_vector_driver_if.master                 m_axis,
    axis_vector_driver_if.slave                  s_axis,
    output logic                                 busy,
    output state_t                               dbg_state
);
    localparam int TXW = $clog2(TX_WORDS_NUM);
    localparam int RXW = $clog2(RX_WORDS_NUM);
    localparam int RCW = $clog2(RX_WORDS_NUM + 1);
    localparam logic [TXW-1:0] TX_LAST = TXW'(TX_WORDS_NUM - 1);
    localparam logic [RCW-1:0] RX_LAST = RCW'(RX_WORDS_NUM - 1);
    localparam logic [RCW-1:0] RX_FULL = RCW'(RX_WORDS_NUM);

    state_t state, state_nxt;
    logic [TXW-1:0] tx_cnt;
    logic [RCW-1:0] rx_cnt;
    logic           err_q;
    logic [TX_WORDS_NUM-1:0][C_DATA_WIDTH-1:0] req_q;
    logic [RX_WORDS_NUM-1:0][C_DATA_WIDTH-1:0] rsp_q;

    logic           req_hs, tx_hs, tx_done, rx_hs, rx_word_bad;
    logic [TXW-1:0] tx_sel;
    logic [RCW-1:0] rx_sel;

    assign req_hs  = (state == IDLE) && req_valid;
    assign tx_hs   = (state == SEND) && m_axis.tready;
    assign tx_done = tx_hs && (tx_cnt == TX_LAST);
    assign rx_hs   = (state == RECV) && s_axis.tvalid;
    assign tx_sel  = TX_LAST - tx_cnt;
    assign rx_sel  = RX_LAST - rx_cnt;
    // tlast must coincide exactly with the final expected word; a saturated count never matches.
    assign rx_word_bad = (s_axis.tlast != (rx_cnt == RX_LAST)) || (s_axis.tkeep != '1);

    always_comb begin
        state_nxt     = state;
        req_ready     = 1'b0;
        m_axis.tvalid = 1'b0;
        s_axis.tready = 1'b0;
        rsp_valid     = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = SEND;
            end
            SEND: begin
                m_axis.tvalid = 1'b1;
                if (tx_done) state_nxt = RECV;
            end
            RECV: begin
                s_axis.tready = 1'b1;
                if (s_axis.tvalid && s_axis.tlast) state_nxt = DONE;
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            state  <= IDLE;
            tx_cnt <= '0;
            rx_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (req_hs) tx_cnt <= '0;
            else if (tx_hs && !tx_done) tx_cnt <= tx_cnt + 1'b1;
            if (tx_done) begin
                rx_cnt <= '0;
                err_q  <= 1'b0;
            end else if (rx_hs) begin
                if (rx_cnt != RX_FULL) rx_cnt <= rx_cnt + 1'b1;
                if (rx_word_bad) err_q <= 1'b1;
            end
        end
    end

    // Vectors carry no reset; the response is zeroed on entry to RECV so short packets read as zero.
    always_ff @(posedge s_axis_aclk) begin
        if (req_hs) req_q <= req_data;
        if (tx_done) rsp_q <= '0;
        else if (rx_hs && rx_cnt != RX_FULL) rsp_q[rx_sel[RXW-1:0]] <= s_axis.tdata;
    end

    assign m_axis.tdata = req_q[tx_sel];
    assign m_axis.tkeep = '1;
    assign m_axis.tlast = (tx_cnt == TX_LAST);
    assign rsp_data     = rsp_q;
    assign rsp_err      = err_q;
    assign busy         = (state != IDLE);
    assign dbg_state    = state;
endmodule
